// File: rtl/vgasync_scaled.sv
// VGA raster timing generator: H/V counters, delayed polarity-selectable syncs and region flags,
// replicated-pixel source coordinates, sticky line-match interrupt and completed-frame counter.
module vgasync_scaled #(
  parameter int HLB     = 64,
  parameter int HVID    = 512,
  parameter int HRB     = 64,
  parameter int HFP     = 16,
  parameter int HS      = 96,
  parameter int HBP     = 48,
  parameter int VTB     = 48,
  parameter int VVID    = 384,
  parameter int VBB     = 48,
  parameter int VFP     = 10,
  parameter int VS      = 2,
  parameter int VBP     = 33,
  parameter int HS_POL  = 1,
  parameter int VS_POL  = 1,
  parameter int XSCALE  = 2,
  parameter int YSCALE  = 2,
  parameter int PIPE    = 2,
  parameter int FC_BITS = 8,
  localparam int HC_MAX  = HLB + HVID + HRB + HFP + HS + HBP,
  localparam int VC_MAX  = VTB + VVID + VBB + VFP + VS + VBP,
  localparam int HC_BITS = $clog2(HC_MAX),
  localparam int VC_BITS = $clog2(VC_MAX),
  localparam int XB      = $clog2(HVID / XSCALE),
  localparam int YB      = $clog2(VVID / YSCALE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VC_BITS-1:0] irq_line,
  input  logic               irq_ack,
  output logic               hsync,
  output logic               vsync,
  output logic               vid_active,
  output logic               bdr_active,
  output logic [HC_BITS-1:0] col,
  output logic [VC_BITS-1:0] row,
  output logic               col_last,
  output logic               row_last,
  output logic [XB-1:0]      vid_x,
  output logic [YB-1:0]      vid_y,
  output logic               end_of_frame,
  output logic               irq,
  output logic [FC_BITS-1:0] frame_ctr
);

  localparam int XSH = $clog2(XSCALE);
  localparam int YSH = $clog2(YSCALE);
  localparam logic [HC_BITS-1:0] COL_END = HC_BITS'(HC_MAX - 1);
  localparam logic [HC_BITS-1:0] ACT_X0  = HC_BITS'(HLB);
  localparam logic [HC_BITS-1:0] ACT_X1  = HC_BITS'(HLB + HVID);
  localparam logic [HC_BITS-1:0] VIS_X1  = HC_BITS'(HLB + HVID + HRB);
  localparam logic [HC_BITS-1:0] HS_X0   = HC_BITS'(HLB + HVID + HRB + HFP);
  localparam logic [HC_BITS-1:0] HS_X1   = HC_BITS'(HLB + HVID + HRB + HFP + HS);
  localparam logic [VC_BITS-1:0] ROW_END = VC_BITS'(VC_MAX - 1);
  localparam logic [VC_BITS-1:0] ACT_Y0  = VC_BITS'(VTB);
  localparam logic [VC_BITS-1:0] ACT_Y1  = VC_BITS'(VTB + VVID);
  localparam logic [VC_BITS-1:0] VIS_Y1  = VC_BITS'(VTB + VVID + VBB);
  localparam logic [VC_BITS-1:0] VS_Y0   = VC_BITS'(VTB + VVID + VBB + VFP);
  localparam logic [VC_BITS-1:0] VS_Y1   = VC_BITS'(VTB + VVID + VBB + VFP + VS);
  localparam logic [VC_BITS:0]   VC_LIM  = (VC_BITS + 1)'(VC_MAX);
  localparam logic               HS_ON   = 1'(HS_POL);
  localparam logic               VS_ON   = 1'(VS_POL);

  logic [HC_BITS-1:0]    col_r;
  logic [VC_BITS-1:0]    row_r;
  logic [PIPE-1:0][3:0]  pipe_r;
  logic                  irq_r;
  logic [FC_BITS-1:0]    frame_r;
  logic                  row_act_s, act_s, bdr_s, hs_s, vs_s;
  logic                  line_end_s, line_hit_s, eof_s;
  logic [XB+XSH-1:0]     x_off_s;
  logic [YB+YSH-1:0]     y_off_s;
  logic [XB-1:0]         vid_x_s;
  logic [YB-1:0]         vid_y_s;

  // Raster counters; the >= compares pull any out-of-range value back to the start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r <= '0;
      row_r <= '0;
    end else if (col_r >= COL_END) begin
      col_r <= '0;
      if (row_r >= ROW_END) row_r <= '0;
      else                  row_r <= row_r + VC_BITS'(1);
    end else begin
      col_r <= col_r + HC_BITS'(1);
    end
  end

  // Region and sync decode of the current raster position.
  always_comb begin
    row_act_s = (row_r >= ACT_Y0) && (row_r < ACT_Y1);
    act_s     = (col_r >= ACT_X0) && (col_r < ACT_X1) && row_act_s;
    bdr_s     = (col_r < VIS_X1) && (row_r < VIS_Y1) && !act_s;
    hs_s      = (col_r >= HS_X0) && (col_r < HS_X1);
    vs_s      = (row_r >= VS_Y0) && (row_r < VS_Y1);
  end

  // Source-pixel coordinates: offset then divide by the replication factor.
  always_comb begin
    x_off_s = (XB + XSH)'(col_r - ACT_X0);
    y_off_s = (YB + YSH)'(row_r - ACT_Y0);
    if (act_s) vid_x_s = x_off_s[XB+XSH-1:XSH];
    else       vid_x_s = '0;
    if (row_act_s) vid_y_s = y_off_s[YB+YSH-1:YSH];
    else           vid_y_s = '0;
  end

  // Delay line aligning region/sync flags with the downstream fetch latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= {act_s, bdr_s, hs_s, vs_s};
      for (int i = 1; i < PIPE; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign line_end_s = (col_r == COL_END);
  // Rows never reach VC_MAX in normal operation, but a stray counter value must not match.
  assign line_hit_s = line_end_s && (row_r == irq_line) && ({1'b0, irq_line} < VC_LIM);
  assign eof_s      = line_end_s && (row_r == ACT_Y1 - VC_BITS'(1));

  // Sticky line interrupt (set beats ack) and completed-frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_r   <= 1'b0;
      frame_r <= '0;
    end else begin
      if (line_hit_s)   irq_r <= 1'b1;
      else if (irq_ack) irq_r <= 1'b0;
      else              irq_r <= irq_r;
      if (eof_s) frame_r <= frame_r + FC_BITS'(1);
      else       frame_r <= frame_r;
    end
  end

  assign hsync        = pipe_r[PIPE-1][1] ? HS_ON : ~HS_ON;
  assign vsync        = pipe_r[PIPE-1][0] ? VS_ON : ~VS_ON;
  assign vid_active   = pipe_r[PIPE-1][3];
  assign bdr_active   = pipe_r[PIPE-1][2];
  assign col          = col_r;
  assign row          = row_r;
  assign col_last     = line_end_s;
  assign row_last     = line_end_s && (row_r == ROW_END);
  assign vid_x        = vid_x_s;
  assign vid_y        = vid_y_s;
  assign end_of_frame = eof_s;
  assign irq          = irq_r;
  assign frame_ctr    = frame_r;

endmodule
